// File: rtl/gem_cluster_packer.sv
// gem_cluster_packer
//
// Finds clusters of adjacent fired S-bits across the 1536 strips of a
// 24-VFAT GEM module and packs the eight lowest-addressed clusters into
// 14-bit words every bunch crossing.
//
// Ports:
//   clock4x            160 MHz clock, all state on the rising edge
//   global_reset       asynchronous, active-low reset
//   vfat0 .. vfat23    64 S-bits each; vfatN[k] is global strip N*64+k
//   truncate_clusters  when set, every reported cluster size is forced to 0
//   cluster0 .. 7      {cnt[2:0], adr[10:0]}, cnt = size-1, adr = lowest strip;
//                      unused slots carry adr=0x7FE, cnt=0
//
// Pipeline (new pattern accepted every cycle, outputs 4 edges after sampling):
//   A  register the strip pattern
//   B  cluster-start flags and saturated run length per strip
//   C  first eight starts inside each 192-strip group
//   D  merge the eight group lists into the eight lowest clusters overall
//   E  format the output words
module gem_cluster_packer (
    input  logic        clock4x,
    input  logic        global_reset,
    input  logic [63:0] vfat0,
    input  logic [63:0] vfat1,
    input  logic [63:0] vfat2,
    input  logic [63:0] vfat3,
    input  logic [63:0] vfat4,
    input  logic [63:0] vfat5,
    input  logic [63:0] vfat6,
    input  logic [63:0] vfat7,
    input  logic [63:0] vfat8,
    input  logic [63:0] vfat9,
    input  logic [63:0] vfat10,
    input  logic [63:0] vfat11,
    input  logic [63:0] vfat12,
    input  logic [63:0] vfat13,
    input  logic [63:0] vfat14,
    input  logic [63:0] vfat15,
    input  logic [63:0] vfat16,
    input  logic [63:0] vfat17,
    input  logic [63:0] vfat18,
    input  logic [63:0] vfat19,
    input  logic [63:0] vfat20,
    input  logic [63:0] vfat21,
    input  logic [63:0] vfat22,
    input  logic [63:0] vfat23,
    input  logic        truncate_clusters,
    output logic [13:0] cluster0,
    output logic [13:0] cluster1,
    output logic [13:0] cluster2,
    output logic [13:0] cluster3,
    output logic [13:0] cluster4,
    output logic [13:0] cluster5,
    output logic [13:0] cluster6,
    output logic [13:0] cluster7
);

    localparam int NUM_STRIPS = 1536;
    localparam int GROUP_SIZE = 192;
    localparam int NUM_GROUPS = NUM_STRIPS / GROUP_SIZE;
    localparam int NUM_SLOTS  = 8;
    localparam int NUM_CANDS  = NUM_GROUPS * NUM_SLOTS;
    localparam int MAX_SIZE   = 8;

    localparam logic [13:0] INVALID_WORD = {3'd0, 11'h7FE};

    logic [NUM_STRIPS-1:0]            strips_in;
    logic [NUM_STRIPS-1:0]            strips_q;
    logic [NUM_STRIPS+MAX_SIZE-2:0]   strips_padded;
    logic [NUM_STRIPS-1:0]            start_c;
    logic [NUM_STRIPS-1:0][2:0]       size_c;
    logic [NUM_STRIPS-1:0]            start_q;
    logic [NUM_STRIPS-1:0][2:0]       size_q;
    logic [NUM_CANDS-1:0]             cand_vld_c;
    logic [NUM_CANDS-1:0][10:0]       cand_adr_c;
    logic [NUM_CANDS-1:0][2:0]        cand_cnt_c;
    logic [NUM_CANDS-1:0]             cand_vld_q;
    logic [NUM_CANDS-1:0][10:0]       cand_adr_q;
    logic [NUM_CANDS-1:0][2:0]        cand_cnt_q;
    logic [NUM_SLOTS-1:0]             slot_vld_c;
    logic [NUM_SLOTS-1:0][10:0]       slot_adr_c;
    logic [NUM_SLOTS-1:0][2:0]        slot_cnt_c;
    logic [NUM_SLOTS-1:0]             slot_vld_q;
    logic [NUM_SLOTS-1:0][10:0]       slot_adr_q;
    logic [NUM_SLOTS-1:0][2:0]        slot_cnt_q;
    logic [NUM_SLOTS-1:0][13:0]       cluster_q;
    // truncate travels with its pattern so a mode change never mixes patterns
    logic [3:0]                       trunc_q;

    assign strips_in = {vfat23, vfat22, vfat21, vfat20, vfat19, vfat18,
                        vfat17, vfat16, vfat15, vfat14, vfat13, vfat12,
                        vfat11, vfat10, vfat9,  vfat8,  vfat7,  vfat6,
                        vfat5,  vfat4,  vfat3,  vfat2,  vfat1,  vfat0};

    // Stage A: capture the pattern
    always_ff @(posedge clock4x or negedge global_reset) begin
        if (!global_reset) begin
            strips_q   <= '0;
            trunc_q[0] <= 1'b0;
        end else begin
            strips_q   <= strips_in;
            trunc_q[0] <= truncate_clusters;
        end
    end

    // Zero padding above strip 1535 so a run simply ends at the top strip
    assign strips_padded = {{(MAX_SIZE-1){1'b0}}, strips_q};

    // A start needs the strip below to be empty; strips past the 8th of a run
    // therefore never start a cluster of their own
    assign start_c = strips_q & ~{strips_q[NUM_STRIPS-2:0], 1'b0};

    // Run length from each strip upwards, saturated at 8, stored as size-1
    always_comb begin
        logic [3:0] run;
        logic       open;
        size_c = '0;
        for (int i = 0; i < NUM_STRIPS; i++) begin
            run  = 4'd0;
            open = 1'b1;
            for (int j = 0; j < MAX_SIZE; j++) begin
                if (open && strips_padded[i+j]) begin
                    run = run + 4'd1;
                end else begin
                    open = 1'b0;
                end
            end
            size_c[i] = (run == 4'd0) ? 3'd0 : 3'(run - 4'd1);
        end
    end

    // Stage B register
    always_ff @(posedge clock4x or negedge global_reset) begin
        if (!global_reset) begin
            start_q    <= '0;
            size_q     <= '0;
            trunc_q[1] <= 1'b0;
        end else begin
            start_q    <= start_c;
            size_q     <= size_c;
            trunc_q[1] <= trunc_q[0];
        end
    end

    // Each group independently extracts its eight lowest starts, in order, so
    // the global merge only has to concatenate ordered lists
    always_comb begin
        logic [GROUP_SIZE-1:0] mask;
        logic                  found;
        cand_vld_c = '0;
        cand_adr_c = '0;
        cand_cnt_c = '0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            mask = start_q[g*GROUP_SIZE +: GROUP_SIZE];
            for (int k = 0; k < NUM_SLOTS; k++) begin
                found = 1'b0;
                for (int i = 0; i < GROUP_SIZE; i++) begin
                    if (!found && mask[i]) begin
                        found                      = 1'b1;
                        mask[i]                    = 1'b0;
                        cand_vld_c[g*NUM_SLOTS+k]  = 1'b1;
                        cand_adr_c[g*NUM_SLOTS+k]  = 11'(g*GROUP_SIZE + i);
                        cand_cnt_c[g*NUM_SLOTS+k]  = size_q[g*GROUP_SIZE + i];
                    end
                end
            end
        end
    end

    // Stage C register
    always_ff @(posedge clock4x or negedge global_reset) begin
        if (!global_reset) begin
            cand_vld_q <= '0;
            cand_adr_q <= '0;
            cand_cnt_q <= '0;
            trunc_q[2] <= 1'b0;
        end else begin
            cand_vld_q <= cand_vld_c;
            cand_adr_q <= cand_adr_c;
            cand_cnt_q <= cand_cnt_c;
            trunc_q[2] <= trunc_q[1];
        end
    end

    // Candidates are already in ascending address order; take the first eight
    // valid ones and drop the rest
    always_comb begin
        logic [3:0] fill;
        slot_vld_c = '0;
        slot_adr_c = '0;
        slot_cnt_c = '0;
        fill       = 4'd0;
        for (int i = 0; i < NUM_CANDS; i++) begin
            if (cand_vld_q[i] && !fill[3]) begin
                slot_vld_c[fill[2:0]] = 1'b1;
                slot_adr_c[fill[2:0]] = cand_adr_q[i];
                slot_cnt_c[fill[2:0]] = cand_cnt_q[i];
                fill                  = fill + 4'd1;
            end
        end
    end

    // Stage D register
    always_ff @(posedge clock4x or negedge global_reset) begin
        if (!global_reset) begin
            slot_vld_q <= '0;
            slot_adr_q <= '0;
            slot_cnt_q <= '0;
            trunc_q[3] <= 1'b0;
        end else begin
            slot_vld_q <= slot_vld_c;
            slot_adr_q <= slot_adr_c;
            slot_cnt_q <= slot_cnt_c;
            trunc_q[3] <= trunc_q[2];
        end
    end

    // Stage E: output words; reset forces every slot to the invalid word
    always_ff @(posedge clock4x or negedge global_reset) begin
        if (!global_reset) begin
            cluster_q <= {NUM_SLOTS{INVALID_WORD}};
        end else begin
            for (int k = 0; k < NUM_SLOTS; k++) begin
                if (slot_vld_q[k]) begin
                    cluster_q[k] <= {(trunc_q[3] ? 3'd0 : slot_cnt_q[k]), slot_adr_q[k]};
                end else begin
                    cluster_q[k] <= INVALID_WORD;
                end
            end
        end
    end

    assign cluster0 = cluster_q[0];
    assign cluster1 = cluster_q[1];
    assign cluster2 = cluster_q[2];
    assign cluster3 = cluster_q[3];
    assign cluster4 = cluster_q[4];
    assign cluster5 = cluster_q[5];
    assign cluster6 = cluster_q[6];
    assign cluster7 = cluster_q[7];

endmodule

// File: tb/tb_gem_cluster_packer.sv
// tb_gem_cluster_packer
//
// Self-checking bench for gem_cluster_packer. Every sampled pattern gets its
// expected eight cluster words from a reference model pushed onto a queue;
// the words are popped and compared when the DUT presents them four edges
// later. Cycles without a result in flight expect all slots invalid.
module tb_gem_cluster_packer;

    localparam logic [13:0]  INVALID_WORD = {3'd0, 11'h7FE};
    localparam logic [111:0] ALL_INVALID  = {8{INVALID_WORD}};

    logic          clock4x = 1'b0;
    logic          global_reset;
    logic          truncate_clusters;
    logic [1535:0] strips_drv;
    logic [13:0]   cluster0, cluster1, cluster2, cluster3;
    logic [13:0]   cluster4, cluster5, cluster6, cluster7;
    logic [111:0]  actual;

    string         cur_tag = "idle";
    int            vectors_applied = 0;
    int            miscompares = 0;
    logic [111:0]  exp_q[$];
    string         tag_q[$];

    always #5 clock4x = ~clock4x;

    gem_cluster_packer dut (
        .clock4x           (clock4x),
        .global_reset      (global_reset),
        .vfat0             (strips_drv[  63:   0]),
        .vfat1             (strips_drv[ 127:  64]),
        .vfat2             (strips_drv[ 191: 128]),
        .vfat3             (strips_drv[ 255: 192]),
        .vfat4             (strips_drv[ 319: 256]),
        .vfat5             (strips_drv[ 383: 320]),
        .vfat6             (strips_drv[ 447: 384]),
        .vfat7             (strips_drv[ 511: 448]),
        .vfat8             (strips_drv[ 575: 512]),
        .vfat9             (strips_drv[ 639: 576]),
        .vfat10            (strips_drv[ 703: 640]),
        .vfat11            (strips_drv[ 767: 704]),
        .vfat12            (strips_drv[ 831: 768]),
        .vfat13            (strips_drv[ 895: 832]),
        .vfat14            (strips_drv[ 959: 896]),
        .vfat15            (strips_drv[1023: 960]),
        .vfat16            (strips_drv[1087:1024]),
        .vfat17            (strips_drv[1151:1088]),
        .vfat18            (strips_drv[1215:1152]),
        .vfat19            (strips_drv[1279:1216]),
        .vfat20            (strips_drv[1343:1280]),
        .vfat21            (strips_drv[1407:1344]),
        .vfat22            (strips_drv[1471:1408]),
        .vfat23            (strips_drv[1535:1472]),
        .truncate_clusters (truncate_clusters),
        .cluster0          (cluster0),
        .cluster1          (cluster1),
        .cluster2          (cluster2),
        .cluster3          (cluster3),
        .cluster4          (cluster4),
        .cluster5          (cluster5),
        .cluster6          (cluster6),
        .cluster7          (cluster7)
    );

    assign actual = {cluster7, cluster6, cluster5, cluster4,
                     cluster3, cluster2, cluster1, cluster0};

    // Reference model: scan strips upwards, report the first eight starts
    function automatic logic [111:0] cluster_model(input logic [1535:0] s, input logic trunc);
        logic [111:0] r;
        int           n;
        int           run;
        logic         prev;
        r = {8{INVALID_WORD}};
        n = 0;
        for (int i = 0; i < 1536; i++) begin
            if (i > 0) prev = s[i-1];
            else       prev = 1'b0;
            if (s[i] && !prev && n < 8) begin
                run = 0;
                for (int j = 0; j < 8; j++) begin
                    if (i + j >= 1536) break;
                    if (!s[i+j]) break;
                    run++;
                end
                r[n*14 +: 14] = {(trunc ? 3'd0 : 3'(run - 1)), 11'(i)};
                n++;
            end
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [111:0] observed, input logic [111:0] expected);
        vectors_applied++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Hold one pattern for a full bunch crossing (4 cycles)
    task automatic applyStimulus(input string tag, input logic [1535:0] pattern, input logic trunc);
        strips_drv        = pattern;
        truncate_clusters = trunc;
        cur_tag           = tag;
        repeat (4) @(negedge clock4x);
    endtask

    // Scoreboard push: one expected result per sampling edge out of reset
    always @(posedge clock4x) begin
        if (global_reset) begin
            exp_q.push_back(cluster_model(strips_drv, truncate_clusters));
            tag_q.push_back(cur_tag);
        end
    end

    always @(negedge global_reset) begin
        exp_q.delete();
        tag_q.delete();
    end

    // Scoreboard pop: result of the edge four cycles back is due now
    always @(negedge clock4x) begin
        logic [111:0] e;
        string        t;
        if (!global_reset) begin
            checkOutput("in_reset", actual, ALL_INVALID);
        end else if (exp_q.size() >= 5) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            checkOutput(t, actual, e);
        end else begin
            checkOutput("latency_fill", actual, ALL_INVALID);
        end
    end

    initial begin
        logic [1535:0] p;
        int            pos;
        int            len;

        global_reset      = 1'b0;
        truncate_clusters = 1'b0;
        strips_drv        = '0;
        repeat (3) @(negedge clock4x);
        global_reset = 1'b1;

        applyStimulus("all_zero", '0, 1'b0);

        p = '0; p[1] = 1'b1;
        applyStimulus("single_1", p, 1'b0);

        for (int k = 2; k <= 10; k++) begin
            p = '0; p[k] = 1'b1;
            applyStimulus("sweep", p, 1'b0);
        end

        p = '0; p[35:0] = 36'h0FF0FF0FF; p[803:768] = 36'h0FF0FF0FF;
        applyStimulus("runs_of_8", p, 1'b0);

        p = '0; p[35:0] = 36'hAAAAAAAAA;
        applyStimulus("overflow", p, 1'b0);

        p = '0;
        for (int b = 0; b < 8; b++) p[b*192 +: 2] = 2'b11;
        applyStimulus("block_pairs", p, 1'b0);
        applyStimulus("block_pairs_trunc", p, 1'b1);
        applyStimulus("block_pairs_untrunc", p, 1'b0);

        p = '0; p[65:62] = 4'hF;
        applyStimulus("cross_vfat", p, 1'b0);

        p = '0; p[109:100] = 10'h3FF;
        applyStimulus("run_of_10", p, 1'b0);

        p = '0; p[1535:1534] = 2'b11;
        applyStimulus("top_strips", p, 1'b0);

        p = '0; p[1535] = 1'b1; p[0] = 1'b1;
        applyStimulus("no_wrap", p, 1'b0);

        for (int r = 0; r < 6; r++) begin
            p = '0;
            for (int n = 0; n < 12; n++) begin
                pos = $urandom_range(0, 1535);
                len = $urandom_range(1, 11);
                for (int j = 0; j < len; j++) begin
                    if (pos + j < 1536) p[pos+j] = 1'b1;
                end
            end
            applyStimulus("random", p, (r == 3));
        end

        // Reset in the middle of traffic: outputs clear at once, nothing stale
        p = '0; p[35:0] = 36'h0FF0FF0FF;
        applyStimulus("busy_pre", p, 1'b0);
        p = '0; p[803:768] = 36'h0FF0FF0FF;
        strips_drv = p;
        cur_tag    = "busy_flight";
        @(negedge clock4x);
        #2 global_reset = 1'b0;
        #1 checkOutput("async_reset", actual, ALL_INVALID);
        repeat (3) @(negedge clock4x);
        global_reset = 1'b1;
        p = '0; p[500] = 1'b1; p[1200 +: 3] = 3'b111;
        applyStimulus("post_reset", p, 1'b0);

        applyStimulus("drain", '0, 1'b0);
        applyStimulus("drain", '0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
